vend_controller: RTL and testbench
==================================

# vend_controller

Vending transaction controller sitting directly downstream of the per-input debounce/edge-detect stages. Consumes their single-cycle pulses for coins, item selects and cancel. Maintains a credit balance, drives a timed dispense strobe per item, and returns change as spaced nickel pulses. Credit is always a multiple of 5 cents.

## Interface
Parameters:
- NUM_ITEMS, 4: number of selectable items.
- CREDIT_W, 8: credit register width, in cents.
- MAX_CREDIT, 200: credit ceiling in cents; must be a multiple of 5 and below 2^CREDIT_W.
- DISPENSE_CYCLES, 62_500_000: dispense hold time (0.5 s at 125 MHz); must be ≥1.
- CHANGE_GAP, 12_500_000: cycles between change pulses (100 ms); must be ≥1.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- coin_5, coin_10, coin_25  in  1 each  one-cycle coin-accepted pulses.
- sel  in  NUM_ITEMS  one-cycle item-select pulses; one-hot expected.
- cancel  in  1  one-cycle cancel/refund pulse.
- credit  out  CREDIT_W  current balance in cents.
- dispense  out  NUM_ITEMS  one-hot level to the item release, held DISPENSE_CYCLES.
- change_5  out  1  one-cycle pulse; each pulse ejects one nickel.
- coin_reject  out  1  one-cycle pulse; the coin sum this cycle was not credited.
- insufficient  out  1  one-cycle pulse; selection made with too little credit.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, DISPENSE, CHANGE.
- Per-item price comes from package constant ITEM_PRICE[i].
- IDLE, coins:
  - coin_sum = 5·coin_5 + 10·coin_10 + 25·coin_25, computed at CREDIT_W+1 bits.
  - If credit + coin_sum ≤ MAX_CREDIT, add it to credit.
  - Otherwise credit is unchanged and coin_reject pulses.
  - Simultaneous coin pulses are summed, all-or-nothing.
- IDLE, selection:
  - A sel value with popcount ≠ 1 is ignored.
  - Valid one-hot with credit ≥ ITEM_PRICE[i]: credit -= price, dispense[i] goes high, go to DISPENSE.
  - Valid one-hot with credit < price: insufficient pulses, stay in IDLE, credit unchanged.
- IDLE, cancel: credit > 0 goes to CHANGE; credit == 0 does nothing.
- Simultaneous events in IDLE:
  - Priority is cancel > valid selection > coins.
  - A coin_sum ≠ 0 in a cycle where cancel acts or a valid selection dispenses is rejected: coin_reject pulses.
  - A coin_sum ≠ 0 in a cycle with an insufficient selection is credited normally.
- DISPENSE:
  - Hold dispense for exactly DISPENSE_CYCLES cycles, then drop it.
  - Then go to CHANGE if credit > 0, else IDLE.
- CHANGE:
  - change_5 pulses on the first CHANGE cycle, then every CHANGE_GAP cycles.
  - credit decrements by 5 on each pulse edge.
  - Go to IDLE on the cycle after the pulse that takes credit to 0.
- Outside IDLE: any coin pulse gives coin_reject; sel and cancel are ignored.
- Reset (asynchronous, any state): state=IDLE, credit=0, all outputs 0, timers cleared. An in-flight dispense or refund is abandoned and not resumed.

## Timing
- All outputs are registered.
- Coin pulse at edge N: credit updated and visible after edge N. coin_reject is high for the cycle following edge N.
- Select at edge N: dispense high from after edge N through DISPENSE_CYCLES cycles. busy rises in the same cycle.
- Entering CHANGE with credit C:
  - The first change_5 pulse is the first CHANGE cycle.
  - Exactly C/5 pulses occur, spaced CHANGE_GAP cycles apart.
  - busy falls one cycle after the last pulse.
- The one shared down-counter is ceil(log2(max(DISPENSE_CYCLES, CHANGE_GAP)+1)) bits wide.
- Width/arithmetic: credit never exceeds MAX_CREDIT, and the decrement never underflows.

## Structure
- Package vend_pkg holds:
  - the state enum (IDLE/DISPENSE/CHANGE)
  - coin value constants
  - the ITEM_PRICE array, default {65, 75, 100, 125}
- Sub-module vend_pulse_timer: a loadable down-counter with a done pulse, used for both the dispense hold and the change gap.

## Test plan
Parameters for the bench: DISPENSE_CYCLES=4, CHANGE_GAP=3.
- Exact payment: coins 25,25,10,5 into credit 65, then sel=0001 → dispense=0001 for 4 cycles, no change_5, credit 0, busy low after 4 cycles.
- Change return: credit 75, sel=0001 → 4-cycle dispense, then 2 change_5 pulses 3 cycles apart, credit 10→5→0, back to IDLE.
- Overflow: credit 190, coin_25 → coin_reject, credit stays 190. Then coin_10 → credit 200.
- Short credit and simultaneous events:
  - credit 50, sel=0100 → insufficient, credit 50.
  - Same cycle cancel+sel+coin_5 → refund path, coin_reject, 10 change pulses.
- Busy lockout: coin_5 and sel=0010 during DISPENSE → coin_reject, no state change. sel=0011 in IDLE → ignored.
- Reset mid-refund: reset_n low during CHANGE with credit 40 → credit 0, change_5 0, busy 0 immediately (asynchronous), IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  // Controller states; also exported on the debug port of vend_controller.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } vend_state_e;

  // Coin values in cents.
  localparam int COIN_5_VAL  = 5;
  localparam int COIN_10_VAL = 10;
  localparam int COIN_25_VAL = 25;

  // Every change pulse ejects one nickel.
  localparam int CHANGE_VAL = 5;

  // Price table in cents, indexed by item number.
  localparam int NUM_PRICES = 4;
  localparam int ITEM_PRICE [NUM_PRICES] = '{65, 75, 100, 125};

  // Price lookup. An item with no entry in the table gets a price no credit
  // register can reach, so it can never be sold by accident.
  function automatic int item_price(input int idx);
    if (idx < NUM_PRICES) return ITEM_PRICE[idx];
    return 32'h7fff_ffff;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter. done_o is high during the last cycle of a loaded
// interval (count == 1), so the owner can act on the edge that ends it.
module vend_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // Load wins over counting; the counter parks at zero once expired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == W'(1));

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: credit accounting, timed dispense strobe
// and spaced nickel change pulses, driven by single-cycle input pulses.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS       = 4,
  parameter int CREDIT_W        = 8,
  parameter int MAX_CREDIT      = 200,
  parameter int DISPENSE_CYCLES = 62_500_000,
  parameter int CHANGE_GAP      = 12_500_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 coin_5,
  input  logic                 coin_10,
  input  logic                 coin_25,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] dispense,
  output logic                 change_5,
  output logic                 coin_reject,
  output logic                 insufficient,
  output logic                 busy,
  output vend_state_e          state_dbg
);

  localparam int TMR_MAX = max_int(DISPENSE_CYCLES, CHANGE_GAP);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SUM_W   = CREDIT_W + 1;

  vend_state_e          state_q;
  logic [CREDIT_W-1:0]  credit_q;
  logic [NUM_ITEMS-1:0] dispense_q;
  logic                 change_5_q;
  logic                 coin_reject_q;
  logic                 insufficient_q;
  logic                 busy_q;

  // Decision terms shared by the FSM and the timer load.
  logic [SUM_W-1:0] coin_sum;
  logic [SUM_W-1:0] credit_plus;
  logic             coin_any;
  logic             coin_fits;
  logic             coin_accept;
  logic [31:0]      price_sel;
  logic             sel_valid;
  logic             funded;
  logic             is_idle;
  logic             cancel_act;
  logic             sale_act;
  logic             short_act;
  logic             pay_out;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  // Coin sum at one bit wider than credit so the ceiling test cannot wrap.
  always_comb begin
    coin_sum    = (coin_5  ? SUM_W'(COIN_5_VAL)  : '0)
                + (coin_10 ? SUM_W'(COIN_10_VAL) : '0)
                + (coin_25 ? SUM_W'(COIN_25_VAL) : '0);
    credit_plus = {1'b0, credit_q} + coin_sum;
    coin_any    = coin_5 | coin_10 | coin_25;
    coin_fits   = (credit_plus <= SUM_W'(MAX_CREDIT));
  end

  // Price of the selected item; only meaningful when sel is one-hot.
  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel[i]) price_sel = 32'(item_price(i));
    end
  end

  // Event arbitration in IDLE: cancel > valid selection > coins.
  always_comb begin
    is_idle     = (state_q == ST_IDLE);
    sel_valid   = $onehot(sel);
    funded      = (32'(credit_q) >= price_sel);
    cancel_act  = is_idle && cancel && (credit_q != '0);
    sale_act    = is_idle && !cancel_act && sel_valid && funded;
    short_act   = is_idle && !cancel_act && sel_valid && !funded;
    coin_accept = is_idle && !cancel_act && !sale_act && coin_any && coin_fits;
    // A change pulse is issued on this edge: refund start, dispense ending
    // with credit left, or the gap between nickels running out.
    pay_out     = cancel_act
               || ((state_q == ST_DISPENSE) && tmr_done && (credit_q != '0))
               || ((state_q == ST_CHANGE)   && tmr_done && (credit_q != '0));
    tmr_load    = sale_act || pay_out;
    tmr_val     = sale_act ? TMR_W'(DISPENSE_CYCLES) : TMR_W'(CHANGE_GAP);
  end

  vend_pulse_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Main FSM with every output registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      dispense_q     <= '0;
      change_5_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      change_5_q     <= 1'b0;
      coin_reject_q  <= coin_any && !coin_accept;
      insufficient_q <= short_act;
      case (state_q)
        ST_IDLE: begin
          if (cancel_act) begin
            state_q    <= ST_CHANGE;
            busy_q     <= 1'b1;
            change_5_q <= 1'b1;
            credit_q   <= credit_q - CREDIT_W'(CHANGE_VAL);
          end else if (sale_act) begin
            state_q    <= ST_DISPENSE;
            busy_q     <= 1'b1;
            dispense_q <= sel;
            credit_q   <= credit_q - CREDIT_W'(price_sel);
          end else if (coin_accept) begin
            credit_q   <= credit_plus[CREDIT_W-1:0];
          end
        end
        ST_DISPENSE: begin
          if (tmr_done) begin
            dispense_q <= '0;
            if (credit_q != '0) begin
              state_q    <= ST_CHANGE;
              change_5_q <= 1'b1;
              credit_q   <= credit_q - CREDIT_W'(CHANGE_VAL);
            end else begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
            end
          end
        end
        ST_CHANGE: begin
          // Credit is a multiple of 5, so checking for zero before each
          // decrement is enough to rule out underflow.
          if (credit_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tmr_done) begin
            change_5_q <= 1'b1;
            credit_q   <= credit_q - CREDIT_W'(CHANGE_VAL);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          dispense_q <= '0;
        end
      endcase
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_5     = change_5_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with short dispense/gap timings.
module tb_vend_controller;
  import vend_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        coin_5, coin_10, coin_25, cancel;
  logic [3:0]  sel;
  logic [7:0]  credit;
  logic [3:0]  dispense;
  logic        change_5, coin_reject, insufficient, busy;
  vend_state_e state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  vend_controller #(
    .NUM_ITEMS       (4),
    .CREDIT_W        (8),
    .MAX_CREDIT      (200),
    .DISPENSE_CYCLES (4),
    .CHANGE_GAP      (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin_5       (coin_5),
    .coin_10      (coin_10),
    .coin_25      (coin_25),
    .sel          (sel),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .change_5     (change_5),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle pulse pattern across a single edge.
  task automatic drive(input logic c5, input logic c10, input logic c25,
                       input logic [3:0] s, input logic can);
    coin_5 = c5; coin_10 = c10; coin_25 = c25; sel = s; cancel = can;
    tick();
    coin_5 = 0; coin_10 = 0; coin_25 = 0; sel = '0; cancel = 0;
  endtask

  // Count change pulses until busy drops; first sample is the current cycle.
  task automatic refund_watch(input int exp_pulses, input string tag);
    int pulses = 0;
    int last = -1;
    int gap_bad = 0;
    int cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      if (change_5 === 1'b1) begin
        if (last >= 0 && (cyc - last) != 3) gap_bad++;
        last = cyc;
        pulses++;
      end
      tick();
      cyc++;
    end
    chk({tag, "_pulses"}, pulses, exp_pulses);
    chk({tag, "_gap"}, gap_bad, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    int cyc;
    int pulses;
    reset_n = 0; coin_5 = 0; coin_10 = 0; coin_25 = 0; sel = '0; cancel = 0;
    repeat (2) tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_change", change_5, 0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset_n = 1;
    tick();

    // Exact payment: 25+25+10+5 = 65, item 0 costs 65.
    drive(0, 0, 1, 4'b0000, 0); chk("t1_c25a", credit, 25);
    drive(0, 0, 1, 4'b0000, 0); chk("t1_c25b", credit, 50);
    drive(0, 1, 0, 4'b0000, 0); chk("t1_c10", credit, 60);
    drive(1, 0, 0, 4'b0000, 0); chk("t1_c5", credit, 65);
    chk("t1_noreject", coin_reject, 0);
    drive(0, 0, 0, 4'b0001, 0);
    chk("t1_disp0", dispense, 4'b0001);
    chk("t1_busy0", busy, 1);
    chk("t1_credit0", credit, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t1_disp_hold", dispense, 4'b0001);
      chk("t1_nochange", change_5, 0);
    end
    tick();
    chk("t1_disp_drop", dispense, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_change_end", change_5, 0);

    // Change return: 75 credit, buy 65, two nickels back three cycles apart.
    repeat (3) drive(0, 0, 1, 4'b0000, 0);
    chk("t2_credit75", credit, 75);
    drive(0, 0, 0, 4'b0001, 0);
    chk("t2_credit10", credit, 10);
    repeat (3) tick();
    chk("t2_disp_hold", dispense, 4'b0001);
    tick();
    chk("t2_disp_drop", dispense, 0);
    chk("t2_pulse1", change_5, 1);
    chk("t2_credit5", credit, 5);
    chk("t2_state_chg", 32'(state_dbg), 32'(ST_CHANGE));
    tick(); chk("t2_gap1", change_5, 0);
    tick(); chk("t2_gap2", change_5, 0);
    tick();
    chk("t2_pulse2", change_5, 1);
    chk("t2_credit0", credit, 0);
    chk("t2_busy_last", busy, 1);
    tick();
    chk("t2_busy_low", busy, 0);
    chk("t2_state_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Overflow at the credit ceiling.
    repeat (7) drive(0, 0, 1, 4'b0000, 0);
    drive(0, 1, 0, 4'b0000, 0);
    drive(1, 0, 0, 4'b0000, 0);
    chk("t3_credit190", credit, 190);
    drive(0, 0, 1, 4'b0000, 0);
    chk("t3_reject25", coin_reject, 1);
    chk("t3_hold190", credit, 190);
    drive(0, 1, 0, 4'b0000, 0);
    chk("t3_accept10", coin_reject, 0);
    chk("t3_credit200", credit, 200);
    drive(1, 0, 0, 4'b0000, 0);
    chk("t3_reject_full", coin_reject, 1);
    chk("t3_hold200", credit, 200);
    drive(0, 0, 0, 4'b0000, 1);
    chk("t3_refund_start", change_5, 1);
    refund_watch(40, "t3_refund");

    // Cancel with no credit is a no-op.
    drive(0, 0, 0, 4'b0000, 1);
    chk("t4_cancel0_busy", busy, 0);
    chk("t4_cancel0_change", change_5, 0);
    // Insufficient selection still credits a coin in the same cycle.
    drive(0, 0, 1, 4'b0001, 0);
    chk("t4_insuf_coin", insufficient, 1);
    chk("t4_insuf_credit", credit, 25);
    chk("t4_insuf_noreject", coin_reject, 0);
    drive(0, 0, 1, 4'b0000, 0);
    chk("t4_credit50", credit, 50);
    drive(0, 0, 0, 4'b0100, 0);
    chk("t4_insuf", insufficient, 1);
    chk("t4_insuf_hold", credit, 50);
    chk("t4_insuf_idle", busy, 0);
    chk("t4_insuf_nodisp", dispense, 0);
    tick();
    chk("t4_insuf_pulse", insufficient, 0);
    // cancel + sel + coin together: refund wins, coin rejected.
    drive(1, 0, 0, 4'b0001, 1);
    chk("t4_sim_reject", coin_reject, 1);
    chk("t4_sim_change", change_5, 1);
    chk("t4_sim_credit", credit, 45);
    chk("t4_sim_nodisp", dispense, 0);
    chk("t4_sim_noinsuf", insufficient, 0);
    refund_watch(10, "t4_refund");

    // Busy lockout during dispense.
    drive(0, 0, 1, 4'b0000, 0);
    drive(0, 0, 1, 4'b0000, 0);
    drive(0, 1, 0, 4'b0000, 0);
    drive(1, 0, 0, 4'b0000, 0);
    drive(0, 0, 0, 4'b0001, 0);
    drive(1, 0, 0, 4'b0010, 0);
    chk("t5_lock_reject", coin_reject, 1);
    chk("t5_lock_disp", dispense, 4'b0001);
    chk("t5_lock_credit", credit, 0);
    chk("t5_lock_state", 32'(state_dbg), 32'(ST_DISPENSE));
    tick();
    chk("t5_lock_rej_end", coin_reject, 0);
    tick();
    chk("t5_lock_hold", dispense, 4'b0001);
    tick();
    chk("t5_lock_drop", dispense, 0);
    chk("t5_lock_idle", busy, 0);
    // Simultaneous coins sum, then a non-one-hot select is ignored.
    drive(1, 1, 1, 4'b0000, 0);
    chk("t5_sum40", credit, 40);
    drive(0, 0, 1, 4'b0000, 0);
    drive(0, 0, 1, 4'b0000, 0);
    drive(0, 1, 0, 4'b0000, 0);
    chk("t5_credit100", credit, 100);
    drive(0, 0, 0, 4'b0011, 0);
    chk("t5_multi_nodisp", dispense, 0);
    chk("t5_multi_idle", busy, 0);
    chk("t5_multi_noinsuf", insufficient, 0);
    chk("t5_multi_credit", credit, 100);

    // Reset in the middle of a refund.
    drive(0, 0, 0, 4'b0000, 1);
    chk("t6_refund_start", credit, 95);
    cyc = 0;
    while (credit !== 8'd40 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t6_reach40", credit, 40);
    chk("t6_reach40_busy", busy, 1);
    reset_n = 0;
    #1;
    chk("t6_async_credit", credit, 0);
    chk("t6_async_change", change_5, 0);
    chk("t6_async_busy", busy, 0);
    tick();
    reset_n = 1;
    tick();
    chk("t6_post_state", 32'(state_dbg), 32'(ST_IDLE));
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (change_5 === 1'b1) pulses++;
      tick();
    end
    chk("t6_no_resume", pulses, 0);
    chk("t6_post_credit", credit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
